// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order retirement sequencer from the ROB head into the register file and memory.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rdy               global ready; 0 freezes state and counters, clears pulses
//   head_*            ROB head entry (valid, ready, type, rob_pos, rd, val, mispredict, target_pc)
//   store_done        LSB finished the outstanding committed store
//   head_pop          combinational dequeue of the ROB head
//   commit*           registered RegFile write pulse with rd/val/rob_pos
//   store_req         registered one-cycle request to the LSB
//   rollback          registered one-cycle flush pulse, redirect_pc valid with it
//   retired_cnt       registered count of popped instructions (wraps)
module commit_ctrl #(
    parameter int ROB_POS_W    = 4,
    parameter int REG_POS_W    = 5,
    parameter int DATA_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 head_valid,
    input  logic                 head_ready,
    input  logic [1:0]           head_type,
    input  logic [ROB_POS_W-1:0] head_rob_pos,
    input  logic [REG_POS_W-1:0] head_rd,
    input  logic [DATA_W-1:0]    head_val,
    input  logic                 head_mispredict,
    input  logic [DATA_W-1:0]    head_target_pc,
    input  logic                 store_done,
    output logic                 head_pop,
    output logic                 commit,
    output logic [REG_POS_W-1:0] commit_rd,
    output logic [DATA_W-1:0]    commit_val,
    output logic [ROB_POS_W-1:0] commit_rob_pos,
    output logic                 store_req,
    output logic                 rollback,
    output logic [DATA_W-1:0]    redirect_pc,
    output logic [31:0]          retired_cnt
);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] flush_cnt;
    logic             accept, is_store, load_fields, commit_nxt, store_nxt, rollback_nxt;

    assign accept      = rdy && state == RUN && head_valid && head_ready;
    assign is_store    = head_type == 2'b10;
    assign load_fields = accept && !is_store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (rdy && rollback_nxt)
                flush_cnt <= CNT_W'(FLUSH_CYCLES);
            else if (rdy && state == FLUSH)
                flush_cnt <= flush_cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (rdy) begin
            case (state)
                RUN:        state_nxt = !accept ? RUN : is_store ? STORE_WAIT : rollback_nxt ? FLUSH : RUN;
                STORE_WAIT: state_nxt = store_done ? RUN : STORE_WAIT;
                FLUSH:      state_nxt = flush_cnt == CNT_W'(1) ? RUN : FLUSH;
                default:    state_nxt = RUN;
            endcase
        end
    end

    // Stores pop only once the LSB confirms the write; everything else pops on acceptance.
    always_comb begin
        head_pop     = load_fields || (rdy && state == STORE_WAIT && store_done);
        commit_nxt   = load_fields && head_type != 2'b11 && head_rd != '0;
        store_nxt    = accept && is_store;
        rollback_nxt = load_fields && head_type == 2'b01 && head_mispredict;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit         <= 1'b0;
            commit_rd      <= '0;
            commit_val     <= '0;
            commit_rob_pos <= '0;
            store_req      <= 1'b0;
            rollback       <= 1'b0;
            redirect_pc    <= '0;
            retired_cnt    <= '0;
        end else begin
            commit    <= commit_nxt;
            store_req <= store_nxt;
            rollback  <= rollback_nxt;
            if (head_pop)
                retired_cnt <= retired_cnt + 32'd1;
            if (load_fields) begin
                commit_rd      <= head_rd;
                commit_val     <= head_val;
                commit_rob_pos <= head_rob_pos;
            end
            if (rollback_nxt)
                redirect_pc <= head_target_pc;
        end
    end
endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: scoreboard bench for commit_ctrl; expected commits queued at pop, checked when commit pulses.
module tb_commit_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        head_valid = 1'b0;
    logic        head_ready = 1'b0;
    logic [1:0]  head_type = 2'b00;
    logic [3:0]  head_rob_pos = '0;
    logic [4:0]  head_rd = '0;
    logic [31:0] head_val = '0;
    logic        head_mispredict = 1'b0;
    logic [31:0] head_target_pc = '0;
    logic        store_done = 1'b0;
    logic        head_pop, commit, store_req, rollback;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val, redirect_pc, retired_cnt;
    logic [3:0]  commit_rob_pos;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = '0;
    logic [40:0] exp_q[$];
    logic [40:0] got;
    logic [40:0] want;

    commit_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .head_valid(head_valid), .head_ready(head_ready), .head_type(head_type),
        .head_rob_pos(head_rob_pos), .head_rd(head_rd), .head_val(head_val),
        .head_mispredict(head_mispredict), .head_target_pc(head_target_pc),
        .store_done(store_done), .head_pop(head_pop), .commit(commit),
        .commit_rd(commit_rd), .commit_val(commit_val), .commit_rob_pos(commit_rob_pos),
        .store_req(store_req), .rollback(rollback), .redirect_pc(redirect_pc),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // Every commit pulse must match the oldest expected retirement.
    always @(negedge clk) begin
        if (rst_n && commit === 1'b1) begin
            checks++;
            got = {commit_rd, commit_val, commit_rob_pos};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected: got rd=%0d val=%h pos=%0d, required no commit", commit_rd, commit_val, commit_rob_pos);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL commit_fields: got %h, required %h", got, want);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input logic v, input logic [1:0] t, input logic [3:0] pos,
                            input logic [4:0] rd, input logic [31:0] val,
                            input logic mp, input logic [31:0] tgt);
        head_valid = v; head_ready = v; head_type = t; head_rob_pos = pos;
        head_rd = rd; head_val = val; head_mispredict = mp; head_target_pc = tgt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({head_pop, commit, commit_rd, commit_val, commit_rob_pos, store_req, rollback, redirect_pc, retired_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: pop=%b commit=%b cnt=%0d, required all 0", head_pop, commit, retired_cnt);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu_stream();
        for (int i = 0; i < 3; i++) begin
            set_head(1'b1, 2'b00, 4'(13 + i), 5'(5 + i), 32'(17 * (i + 1)), 1'b0, '0);
            #1;
            checks++;
            if (head_pop !== 1'b1) begin
                errors++;
                $display("FAIL alu_pop%0d: head_pop=%b, required 1", i, head_pop);
            end
            exp_q.push_back({5'(5 + i), 32'(17 * (i + 1)), 4'(13 + i)});
            exp_cnt++;
            step();
        end
        set_head(1'b0, 2'b00, '0, '0, '0, 1'b0, '0);
        checks++;
        if (retired_cnt !== 32'd3) begin
            errors++;
            $display("FAIL alu_cnt: retired_cnt=%0d, required 3", retired_cnt);
        end
        step();
    endtask

    task automatic test_rd0();
        set_head(1'b1, 2'b00, 4'd0, 5'd0, 32'hdead, 1'b0, '0);
        #1;
        checks++;
        if (head_pop !== 1'b1) begin
            errors++;
            $display("FAIL rd0_pop: head_pop=%b, required 1", head_pop);
        end
        exp_cnt++;
        step();
        set_head(1'b0, 2'b00, '0, '0, '0, 1'b0, '0);
        checks++;
        if (commit !== 1'b0 || retired_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL rd0_commit: commit=%b cnt=%0d, required 0 and %0d", commit, retired_cnt, exp_cnt);
        end
        step();
    endtask

    task automatic test_store();
        set_head(1'b1, 2'b10, 4'd2, 5'd8, 32'h77, 1'b0, '0);
        #1;
        checks++;
        if (head_pop !== 1'b0) begin
            errors++;
            $display("FAIL store_nopop: head_pop=%b, required 0", head_pop);
        end
        step();
        checks++;
        if (store_req !== 1'b1 || commit !== 1'b0) begin
            errors++;
            $display("FAIL store_req: store_req=%b commit=%b, required 1 and 0", store_req, commit);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (head_pop !== 1'b0) begin
                errors++;
                $display("FAIL store_wait%0d: head_pop=%b, required 0", i, head_pop);
            end
            step();
            checks++;
            if (store_req !== 1'b0) begin
                errors++;
                $display("FAIL store_req_pulse%0d: store_req=%b, required 0", i, store_req);
            end
        end
        store_done = 1'b1;
        #1;
        checks++;
        if (head_pop !== 1'b1) begin
            errors++;
            $display("FAIL store_done_pop: head_pop=%b, required 1", head_pop);
        end
        exp_cnt++;
        step();
        store_done = 1'b0;
        checks++;
        if (commit !== 1'b0 || retired_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL store_retire: commit=%b cnt=%0d, required 0 and %0d", commit, retired_cnt, exp_cnt);
        end
        set_head(1'b1, 2'b00, 4'd3, 5'd3, 32'h55, 1'b0, '0);
        #1;
        checks++;
        if (head_pop !== 1'b1) begin
            errors++;
            $display("FAIL store_back_to_run: head_pop=%b, required 1", head_pop);
        end
        exp_q.push_back({5'd3, 32'h55, 4'd3});
        exp_cnt++;
        step();
        set_head(1'b0, 2'b00, '0, '0, '0, 1'b0, '0);
        step();
    endtask

    task automatic test_mispredict();
        set_head(1'b1, 2'b01, 4'd4, 5'd1, 32'h1004, 1'b1, 32'h2000);
        #1;
        checks++;
        if (head_pop !== 1'b1) begin
            errors++;
            $display("FAIL mp_pop: head_pop=%b, required 1", head_pop);
        end
        exp_q.push_back({5'd1, 32'h1004, 4'd4});
        exp_cnt++;
        step();
        checks++;
        if (rollback !== 1'b1 || redirect_pc !== 32'h2000 || commit !== 1'b1) begin
            errors++;
            $display("FAIL mp_rollback: rollback=%b pc=%h commit=%b, required 1 2000 1", rollback, redirect_pc, commit);
        end
        set_head(1'b1, 2'b00, 4'd5, 5'd9, 32'h99, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (head_pop !== 1'b0) begin
                errors++;
                $display("FAIL mp_flush%0d: head_pop=%b, required 0", i, head_pop);
            end
            step();
            checks++;
            if (rollback !== 1'b0) begin
                errors++;
                $display("FAIL mp_rollback_pulse%0d: rollback=%b, required 0", i, rollback);
            end
        end
        checks++;
        if (head_pop !== 1'b1) begin
            errors++;
            $display("FAIL mp_resume: head_pop=%b, required 1", head_pop);
        end
        exp_q.push_back({5'd9, 32'h99, 4'd5});
        exp_cnt++;
        step();
        set_head(1'b0, 2'b00, '0, '0, '0, 1'b0, '0);
        step();
    endtask

    task automatic test_rdy_stall();
        set_head(1'b1, 2'b00, 4'd6, 5'd10, 32'hA0, 1'b0, '0);
        #1;
        exp_q.push_back({5'd10, 32'hA0, 4'd6});
        exp_cnt++;
        step();
        set_head(1'b1, 2'b00, 4'd7, 5'd11, 32'hB0, 1'b0, '0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (head_pop !== 1'b0) begin
                errors++;
                $display("FAIL stall_pop%0d: head_pop=%b, required 0", i, head_pop);
            end
            step();
            checks++;
            if (commit !== 1'b0 || retired_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL stall_frozen%0d: commit=%b cnt=%0d, required 0 and %0d", i, commit, retired_cnt, exp_cnt);
            end
        end
        rdy = 1'b1;
        #1;
        checks++;
        if (head_pop !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: head_pop=%b, required 1", head_pop);
        end
        exp_q.push_back({5'd11, 32'hB0, 4'd7});
        exp_cnt++;
        step();
        set_head(1'b1, 2'b00, 4'd8, 5'd12, 32'hC0, 1'b0, '0);
        exp_q.push_back({5'd12, 32'hC0, 4'd8});
        exp_cnt++;
        step();
        set_head(1'b0, 2'b00, '0, '0, '0, 1'b0, '0);
        checks++;
        if (retired_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL stall_cnt: retired_cnt=%0d, required %0d", retired_cnt, exp_cnt);
        end
        step();
    endtask

    task automatic test_async_reset();
        set_head(1'b1, 2'b10, 4'd9, 5'd0, 32'h0, 1'b0, '0);
        step();
        set_head(1'b0, 2'b00, '0, '0, '0, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        checks++;
        if ({head_pop, commit, commit_rd, commit_val, commit_rob_pos, store_req, rollback, redirect_pc, retired_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: store_req=%b cnt=%0d pc=%h, required all 0", store_req, retired_cnt, redirect_pc);
        end
        step();
        rst_n = 1'b1;
        store_done = 1'b1;
        #1;
        checks++;
        if (head_pop !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_pop: head_pop=%b, required 0", head_pop);
        end
        step();
        store_done = 1'b0;
        checks++;
        if (retired_cnt !== 32'd0 || commit !== 1'b0 || store_req !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_state: cnt=%0d commit=%b store_req=%b, required 0", retired_cnt, commit, store_req);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_rd0();
        test_store();
        test_mispredict();
        test_rdy_stall();
        test_async_reset();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_commits: %0d pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
